// File: rtl/inst_mem_ctrl.sv
// Instruction memory with registered read, LATENCY-cycle fetch handshake,
// illegal-fetch reporting and a word-wide program port.
module inst_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     resp_valid,
  output logic [DATA_W-1:0]        inst,
  output logic                     err,
  output logic                     stall_req,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [DATA_W-1:0]        prog_data
);

  localparam int         OFS          = $clog2(DATA_W / 8);
  localparam int         IDX_W        = $clog2(DEPTH);
  localparam logic [3:0] LOAD_CNT     = 4'(LATENCY - 1);
  localparam bit         SINGLE_CYCLE = (LATENCY == 32'sd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned byte offset or word index at/after DEPTH.
  function automatic logic fetch_illegal(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] lo_mask;
    logic [ADDR_W-1:0] idx;
    lo_mask = ADDR_W'((64'd1 << OFS) - 64'd1);
    idx     = a >> OFS;
    return ((a & lo_mask) != {ADDR_W{1'b0}}) ||
           ({1'b0, idx} >= (ADDR_W + 1)'(DEPTH));
  endfunction

  logic [DATA_W-1:0] mem_r [DEPTH];

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_nxt_s;
  logic              accept_s;
  logic              illegal_s;
  logic [ADDR_W-1:0] word_idx_s;
  logic [DATA_W-1:0] rd_word_s;
  logic [DATA_W-1:0] hold_data_r;
  logic              hold_err_r;
  logic [DATA_W-1:0] inst_r;
  logic              err_r;
  logic              resp_valid_r;

  assign req_ready  = ~rst & ce & ((state_r == IDLE) | (state_r == RESP));
  assign stall_req  = ce & req_valid & ~req_ready;
  assign accept_s   = req_valid & req_ready;
  assign illegal_s  = fetch_illegal(addr);
  assign word_idx_s = addr >> OFS;
  assign rd_word_s  = mem_r[word_idx_s[IDX_W-1:0]];

  assign resp_valid = resp_valid_r;
  assign inst       = inst_r;
  assign err        = err_r;

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          state_nxt_s = SINGLE_CYCLE ? RESP : WAIT;
          cnt_nxt_s   = LOAD_CNT;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = cnt_r;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Word read at the accept edge, held while the fetch sits in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_data_r <= {DATA_W{1'b0}};
      hold_err_r  <= 1'b0;
    end else if (accept_s) begin
      hold_data_r <= illegal_s ? {DATA_W{1'b0}} : rd_word_s;
      hold_err_r  <= illegal_s;
    end else begin
      hold_data_r <= hold_data_r;
      hold_err_r  <= hold_err_r;
    end
  end

  // Response registers: only non-zero during the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      inst_r       <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
    end else if (state_nxt_s == RESP) begin
      resp_valid_r <= 1'b1;
      if (accept_s) begin
        inst_r <= illegal_s ? {DATA_W{1'b0}} : rd_word_s;
        err_r  <= illegal_s;
      end else begin
        inst_r <= hold_data_r;
        err_r  <= hold_err_r;
      end
    end else begin
      resp_valid_r <= 1'b0;
      inst_r       <= {DATA_W{1'b0}};
      err_r        <= 1'b0;
    end
  end

  // Program port; the read above sees the pre-write word on a same-edge hit.
  always_ff @(posedge clk) begin
    if (prog_we && !rst) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

endmodule

// File: doc/inst_mem_ctrl.md
# inst_mem_ctrl

Parametrised instruction memory with a registered read path, configurable read latency and a valid/ready fetch handshake, replacing the purely combinational instruction ROM in the fetch stage. It sits between the IF stage and the pipeline controller. It reports illegal fetches, raises a stall request while a fetch is pending, and has a word-wide program port for loading code before or during execution.

## Interface

Parameters:
- `DATA_W`, 32: instruction width in bits. Must be a multiple of 8 and a power of two.
- `ADDR_W`, 32: byte-address width.
- `DEPTH`, 2048: number of instruction words. Must be a power of two.
- `LATENCY`, 1: cycles from the accept edge to `resp_valid`. Legal range is 1..15.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `ce`, in, 1: chip enable. Gates acceptance of new requests only.
- `req_valid`, in, 1: fetch request present.
- `req_ready`, out, 1: block can accept a request this cycle.
- `addr`, in, ADDR_W: byte address of the fetch.
- `resp_valid`, out, 1: single-cycle response strobe.
- `inst`, out, DATA_W: fetched word. Zero whenever `resp_valid` is 0 or `err` is 1.
- `err`, out, 1: qualified by `resp_valid`. The fetch was misaligned or out of range.
- `stall_req`, out, 1: `ce & req_valid & ~req_ready`. Goes to the pipeline controller.
- `prog_we`, in, 1: program-port write enable.
- `prog_addr`, in, log2(DEPTH): word index for the program write.
- `prog_data`, in, DATA_W: word to write.

## Operation

- Define OFS = log2(DATA_W/8).
- Word index = `addr >> OFS`.
- A fetch is misaligned if `addr[OFS-1:0] != 0`.
- A fetch is out of range if the word index is DEPTH or greater.
- Either condition sets `err` = 1 and `inst` = 0 in that fetch's response.
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- `req_ready` = `~rst & ce & (state == IDLE | state == RESP)`.
- Accept happens on an edge where `req_valid & req_ready` = 1. At the accept edge the block:
  - latches the err flag,
  - reads the memory word (read-first),
  - loads the wait counter with LATENCY-1.
- Transitions:
  - IDLE + accept goes to RESP when LATENCY = 1, otherwise to WAIT.
  - IDLE with no accept stays in IDLE.
  - WAIT decrements the counter each cycle and goes to RESP when the counter reaches 0 (i.e. LATENCY-1 WAIT cycles).
  - RESP + accept behaves exactly like accept from IDLE.
  - RESP with no accept goes to IDLE.
- Only one request is ever in flight. The response carries no backpressure, and `resp_valid` is high only in RESP.
- `ce` deasserted while a fetch is in WAIT: the fetch still completes and responds.
- Program port:
  - When `prog_we & ~rst`, `mem[prog_addr]` takes `prog_data` at the edge. Writes are legal in every state.
  - A write at the same edge as an accept to the same index: the fetch returns the OLD word.
  - A write while a fetch is in WAIT is not reflected in that fetch's response.
- Reset:
  - `rst` forces the FSM to IDLE and clears the counter, `resp_valid`, `err` and `inst`.
  - An in-flight fetch is discarded and produces no response.
  - Memory contents are NOT cleared by reset. Program writes are ignored while `rst` = 1.

## Timing

- Reset values: `req_ready` 0 while `rst` = 1; `resp_valid` 0, `inst` 0, `err` 0; `stall_req` = `ce & req_valid`.
- Latency: a request accepted at edge t produces `resp_valid` during the cycle after edge t+LATENCY-1, i.e. LATENCY cycles after the request was presented.
- Throughput:
  - LATENCY = 1: one fetch per cycle with back-to-back accepts in RESP.
  - LATENCY = N: one fetch per N cycles.
- `req_ready` and `stall_req` are combinational from state, `ce`, `rst` and `req_valid`. There is no combinational path from `addr` to any output.
- `inst` and `err` are registered and stable for the whole RESP cycle.

## Test plan

- **Load and back-to-back fetch.** LATENCY=1. Program words 0..3 with 0x24010001, 0x24020002, 0x24030003, 0x24040004. Hold `req_valid` with `addr` = 0, 4, 8, 12 on consecutive cycles -> `resp_valid` stays high for 4 consecutive cycles, `inst` returns the four words in order, and `stall_req` stays 0 throughout.
- **Multi-cycle latency.** LATENCY=3. Fetch `addr` = 8 -> `req_ready` = 0 and `stall_req` = 1 for 2 cycles, then `resp_valid` with `inst` = 0x24030003. The next accept occurs in the RESP cycle.
- **Illegal fetches.** Fetch `addr` = 0x6 -> `err` = 1, `inst` = 0. With DEPTH = 2048, fetch `addr` = 0x2000 -> `err` = 1, `inst` = 0.
- **Write/read collision.** At the same edge, set `prog_we` with `prog_addr` = 1 and `prog_data` = 0xDEADBEEF, and accept `addr` = 4 -> the response is 0x24020002. A following fetch of `addr` = 4 returns 0xDEADBEEF.
- **Reset mid-fetch.** LATENCY=4. Accept `addr` = 0, then assert `rst` for 1 cycle in WAIT -> no `resp_valid` ever appears for that fetch. After reset, `addr` = 0 still returns 0x24010001 (memory retained).
- **Chip enable low.** `ce` = 0 with `req_valid` = 1 -> `req_ready` = 0, `stall_req` = 0, no response. `ce` dropped during WAIT -> the pending response is still delivered.
